demux_stripe: RTL
=================

Name: demux_stripe

Overview:
- Parametrised byte-lane de-striper for the PCIe physical layer receive path; generalises the fixed 2-in/4-out demux.
- IN_LANES input lanes; each lane distributes successive valid symbols round-robin across FAN output lanes of its own group.
- Adds per-lane alignment, a group-complete indication and a visible selector state.
- Sits between the lane deskew stage and the per-lane byte-unstriping / descrambler logic.

Parameters:
- WIDTH, 8, symbol width in bits.
- IN_LANES, 2, number of input lanes; must be at least 1.
- FAN, 2, output lanes per input lane; must be a power of two and at least 2.
- SELW, $clog2(FAN), selector width; derived, not to be overridden.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- in_data  in  IN_LANES*WIDTH  input symbols; lane i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  IN_LANES  per-lane qualifier for in_data.
- align  in  IN_LANES  per-lane realign request; forces that lane's selector back to output 0.
- out_data  out  IN_LANES*FAN*WIDTH  output symbols; output o = i*FAN+k occupies [o*WIDTH +: WIDTH].
- out_valid  out  IN_LANES*FAN  per-output qualifier, registered.
- group_done  out  IN_LANES  one-cycle pulse when lane i has delivered a symbol to its last output (k = FAN-1).
- sel  out  IN_LANES*SELW  current selector of each lane; lane i occupies [i*SELW +: SELW].

Behaviour:
- Reset (reset=1 at a rising edge):
  - out_data, out_valid, group_done and sel are all cleared to 0.
  - Reset has priority over in_valid and align.
- Lanes are fully independent; there is no cross-lane interaction.
- Each output is owned by exactly one input lane (outputs i*FAN .. i*FAN+FAN-1).
- Per lane i, per rising edge without reset, with s = sel[i]:
  - in_valid[i]=1, align[i]=0:
    - out_data[i*FAN+s] <= in_data[i]; out_valid[i*FAN+s] <= 1.
    - sel[i] <= (s+1) mod FAN.
    - group_done[i] <= 1 if s == FAN-1, else 0.
  - in_valid[i]=1, align[i]=1:
    - Symbol goes to output k=0: out_data[i*FAN] <= in_data[i]; out_valid[i*FAN] <= 1.
    - sel[i] <= 1.
    - group_done[i] <= 0.
  - in_valid[i]=0, align[i]=1:
    - sel[i] <= 0; no output valid; group_done[i] <= 0.
  - in_valid[i]=0, align[i]=0:
    - sel[i] holds; no output valid; group_done[i] <= 0.
  - All other outputs of lane i: out_valid <= 0 and out_data holds its last value. Data is never cleared except by reset.
- Latency: exactly 1 cycle from an input symbol to its registered output. No backpressure; the block accepts one symbol per lane per cycle.
- Selector wrap: FAN-1 -> 0 occurs only on a valid symbol. Invalid cycles never advance or wrap the selector.
- Reset mid-group: the partial group is discarded. The next valid symbol goes to output k=0.
- Within a lane, at most one out_valid bit is high per cycle. Across lanes, up to IN_LANES bits may be high in the same cycle.
- Both the selector and out_data update only on valid (or align) cycles; no X must propagate from in_data sampled when in_valid=0.

Test Plan (WIDTH=8, IN_LANES=2, FAN=2 unless stated):
- Reset: hold reset=1 for 2 cycles with in_valid=2'b11 and in_data=16'hFFFF -> all outputs 0 and sel=0 throughout.
- Round-robin: lane0 valid with symbols 0xA1, 0xA2, 0xA3 on consecutive cycles -> one cycle later:
  - out0=0xA1/v, then out1=0xA2/v with group_done[0]=1, then out0=0xA3/v.
  - out_valid[3:2] stays 0 throughout.
- Gaps: lane1 sends 0x11, idle, idle, 0x22 -> out2=0x11/v, then 2 idle cycles with out2 holding 0x11 and valid 0, then out3=0x22/v with group_done[1]=1.
- Align: lane0 sends 0xB1 (sel->1), then 0xB2 with align[0]=1 -> out0=0xB2/v and sel[0]=1; next 0xB3 -> out1=0xB3/v with group_done[0]=1.
- Reset mid-group: lane0 sends 0xC1, then reset for 1 cycle, then 0xC2 -> out0=0x00 after reset; out0=0xC2/v (not out1).
- Scaling: IN_LANES=4, FAN=4, all lanes send lane_id*16+n for n=0..7 -> each output k of lane i receives n=k and then n=k+4; group_done pulses on n=3 and n=7.

Source files
------------

// File: rtl/demux_stripe.sv
// ---------------------------------------------------------------------------
// demux_stripe
//
// Byte-lane de-striper for the PCIe physical layer receive path. Each of the
// IN_LANES input lanes owns a group of FAN output lanes and hands out its
// successive valid symbols round-robin across that group. A per-lane align
// request restarts the rotation at output 0. The lane also reports when a
// symbol has landed on the last output of its group, and exposes its current
// selector.
//
// Parameters:
//   WIDTH     symbol width in bits
//   IN_LANES  number of input lanes (>= 1)
//   FAN       output lanes per input lane (power of two, >= 2)
//   SELW      selector width, derived from FAN; leave at its default
//
// Ports:
//   clk         rising-edge clock for all state
//   reset       synchronous active-high reset
//   in_data     input symbols, lane i at [i*WIDTH +: WIDTH]
//   in_valid    per-lane qualifier for in_data
//   align       per-lane realign request (selector back to output 0)
//   out_data    output symbols, output o = i*FAN+k at [o*WIDTH +: WIDTH]
//   out_valid   per-output qualifier, registered
//   group_done  one-cycle pulse when lane i wrote its last output (k = FAN-1)
//   sel         current selector of lane i at [i*SELW +: SELW]
// ---------------------------------------------------------------------------
module demux_stripe #(
    parameter int WIDTH    = 8,
    parameter int IN_LANES = 2,
    parameter int FAN      = 2,
    parameter int SELW     = $clog2(FAN)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IN_LANES*WIDTH-1:0]     in_data,
    input  logic [IN_LANES-1:0]           in_valid,
    input  logic [IN_LANES-1:0]           align,
    output logic [IN_LANES*FAN*WIDTH-1:0] out_data,
    output logic [IN_LANES*FAN-1:0]       out_valid,
    output logic [IN_LANES-1:0]           group_done,
    output logic [IN_LANES*SELW-1:0]      sel
);

    localparam logic [SELW-1:0] SEL_ONE  = SELW'(1);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(FAN - 1);

    // Packed views whose bit layout matches the flat port vectors, so lane i
    // output k lands exactly at [(i*FAN+k)*WIDTH +: WIDTH].
    logic [IN_LANES-1:0][WIDTH-1:0]          lane_in;
    logic [IN_LANES-1:0][FAN-1:0][WIDTH-1:0] data_q;
    logic [IN_LANES-1:0][FAN-1:0]            valid_q;
    logic [IN_LANES-1:0]                     done_q;
    logic [IN_LANES-1:0][SELW-1:0]           sel_q;

    assign lane_in    = in_data;
    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign group_done = done_q;
    assign sel        = sel_q;

    // Every lane is handled independently. Valid and done flags default to
    // low each cycle and are raised only for the output written this cycle.
    // Output data registers are touched only when a symbol is accepted, so a
    // don't-care in_data on idle cycles never reaches the outputs. Because
    // FAN is a power of two, the selector increment wraps FAN-1 -> 0 on its
    // own, and only ever on a valid symbol.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
            sel_q   <= '0;
        end else begin
            for (int i = 0; i < IN_LANES; i++) begin
                valid_q[i] <= '0;
                done_q[i]  <= 1'b0;
                if (in_valid[i]) begin
                    if (align[i]) begin
                        // Realign with a symbol: the symbol itself opens
                        // the new group at output 0.
                        data_q[i][0]  <= lane_in[i];
                        valid_q[i][0] <= 1'b1;
                        sel_q[i]      <= SEL_ONE;
                    end else begin
                        data_q[i][sel_q[i]]  <= lane_in[i];
                        valid_q[i][sel_q[i]] <= 1'b1;
                        sel_q[i]             <= sel_q[i] + SEL_ONE;
                        done_q[i]            <= (sel_q[i] == SEL_LAST);
                    end
                end else if (align[i]) begin
                    sel_q[i] <= '0;
                end
            end
        end
    end

endmodule
